cell_comm_link_merge: RTL and testbench

//  N-link successor to the two-link CW/CCW receive path: buffers fixed-length BPM packets from
//  NUM_LINKS Aurora RX AXIS streams, commits only CRC-clean well-formed packets, and

---
 rtl/cell_comm_link_merge.sv | 241 ++++++++++++++++++++++++
 tb/tb_cell_comm_link_merge.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_comm_link_merge.sv
// N-link BPM packet receive buffer and round-robin merger onto a single AXIS output.
// Optional duplicate suppression per FA cycle: define CELL_COMM_MERGE_DEDUP_EN.
module cell_comm_link_merge #(
   parameter int NUM_LINKS      = 2,
   parameter int DATA_WIDTH     = 32,
   parameter int FOFB_IDX_WIDTH = 9,
   parameter int PKT_WORDS      = 4,
   parameter int FIFO_AW        = 5,
   localparam int LINK_W        = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1
) (
   input  logic                            sysClk,
   input  logic                            sysReset,
   input  logic                            sysFaStrobe,
   input  logic [NUM_LINKS-1:0]            rxChannelUp,
   input  logic [NUM_LINKS-1:0]            rxTvalid,
   input  logic [NUM_LINKS-1:0]            rxTlast,
   input  logic [NUM_LINKS*DATA_WIDTH-1:0] rxTdata,
   input  logic [NUM_LINKS-1:0]            rxCRCvalid,
   input  logic [NUM_LINKS-1:0]            rxCRCpass,
   output logic                            outTvalid,
   output logic                            outTlast,
   output logic [DATA_WIDTH-1:0]           outTdata,
   input  logic                            outTready,
   output logic [LINK_W-1:0]               outLink,
   output logic [NUM_LINKS*32-1:0]         crcFaults,
   output logic [NUM_LINKS*32-1:0]         dropCount,
   output logic [31:0]                     dupCount,
   output logic [31:0]                     fwdCount
);

   localparam int DEPTH  = 2**FIFO_AW;
   localparam int PTR_W  = FIFO_AW + 1;
   localparam int CNT_W  = $clog2(PKT_WORDS + 2);
   localparam int WCNT_W = $clog2(PKT_WORDS);

   typedef enum logic [1:0] {IDLE, CHECK, FWD, DROP} state_t;
   state_t state, state_nxt;

   logic [DATA_WIDTH-1:0] mem [NUM_LINKS][DEPTH];
   logic [PTR_W-1:0]      wr_ptr     [NUM_LINKS];
   logic [PTR_W-1:0]      commit_ptr [NUM_LINKS];
   logic [PTR_W-1:0]      rd_ptr     [NUM_LINKS];
   logic [PTR_W-1:0]      pending    [NUM_LINKS];
   logic [CNT_W-1:0]      beat_cnt   [NUM_LINKS];
   logic [31:0]           crc_cnt    [NUM_LINKS];
   logic [31:0]           drop_cnt   [NUM_LINKS];
   logic [NUM_LINKS-1:0]  discard, full, wr_en, commit;

   logic [LINK_W-1:0]     rr_ptr, grant;
   logic                  grant_ok;
   logic [WCNT_W-1:0]     word_cnt;
   logic [DATA_WIDTH-1:0] head;
   logic                  pop, pkt_done, dup_hit;
   logic [31:0]           fwd_cnt;

   // A beat is stored only if it can still belong to a well-formed, CRC-clean packet.
   always_comb begin
      for (int unsigned k = 0; k < NUM_LINKS; k++) begin
         full[k]   = (wr_ptr[k] - rd_ptr[k]) == PTR_W'(DEPTH);
         wr_en[k]  = rxChannelUp[k] && rxTvalid[k] && !discard[k] && !full[k]
                     && (beat_cnt[k] != CNT_W'(PKT_WORDS))
                     && (!rxTlast[k] || ((beat_cnt[k] == CNT_W'(PKT_WORDS-1))
                                         && rxCRCvalid[k] && rxCRCpass[k]));
         commit[k] = wr_en[k] && rxTlast[k];
      end
   end

   always_ff @(posedge sysClk) begin
      for (int unsigned k = 0; k < NUM_LINKS; k++) begin
         if (wr_en[k])
            mem[k][wr_ptr[k][FIFO_AW-1:0]] <= rxTdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_ff @(posedge sysClk) begin
      if (sysReset) begin
         for (int unsigned k = 0; k < NUM_LINKS; k++) begin
            wr_ptr[k]     <= '0;
            commit_ptr[k] <= '0;
            beat_cnt[k]   <= '0;
            discard[k]    <= 1'b0;
            crc_cnt[k]    <= '0;
            drop_cnt[k]   <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < NUM_LINKS; k++) begin
            if (!rxChannelUp[k]) begin
               if (beat_cnt[k] != '0) begin
                  wr_ptr[k]   <= commit_ptr[k];
                  drop_cnt[k] <= drop_cnt[k] + 32'd1;
               end
               beat_cnt[k] <= '0;
               discard[k]  <= 1'b0;
            end else if (rxTvalid[k]) begin
               if (discard[k]) begin
                  if (rxTlast[k])
                     discard[k] <= 1'b0;
               end else if (full[k] || beat_cnt[k] == CNT_W'(PKT_WORDS)) begin
                  // overflow or overlong: abandon and swallow the rest of the packet
                  wr_ptr[k]   <= commit_ptr[k];
                  drop_cnt[k] <= drop_cnt[k] + 32'd1;
                  beat_cnt[k] <= '0;
                  discard[k]  <= !rxTlast[k];
               end else if (rxTlast[k]) begin
                  beat_cnt[k] <= '0;
                  if (wr_en[k]) begin
                     wr_ptr[k]     <= wr_ptr[k] + PTR_W'(1);
                     commit_ptr[k] <= wr_ptr[k] + PTR_W'(1);
                  end else begin
                     wr_ptr[k] <= commit_ptr[k];
                     if (beat_cnt[k] != CNT_W'(PKT_WORDS-1))
                        drop_cnt[k] <= drop_cnt[k] + 32'd1;
                     else
                        crc_cnt[k] <= crc_cnt[k] + 32'd1;
                  end
               end else begin
                  wr_ptr[k]   <= wr_ptr[k] + PTR_W'(1);
                  beat_cnt[k] <= beat_cnt[k] + CNT_W'(1);
               end
            end
         end
      end
   end

   assign head = mem[outLink][rd_ptr[outLink][FIFO_AW-1:0]];

   always_comb begin
      int unsigned cand;
      cand      = 0;
      state_nxt = state;
      grant     = rr_ptr;
      grant_ok  = 1'b0;
      pop       = 1'b0;
      pkt_done  = 1'b0;
      outTvalid = 1'b0;
      outTlast  = 1'b0;
      outTdata  = '0;
      for (int unsigned i = 1; i <= NUM_LINKS; i++) begin
         cand = 32'(rr_ptr) + i;
         if (cand >= NUM_LINKS)
            cand = cand - NUM_LINKS;
         if (!grant_ok && pending[cand] != '0) begin
            grant    = LINK_W'(cand);
            grant_ok = 1'b1;
         end
      end
      case (state)
         IDLE:  if (grant_ok) state_nxt = CHECK;
         CHECK: state_nxt = dup_hit ? DROP : FWD;
         FWD: begin
            outTvalid = 1'b1;
            outTdata  = head;
            outTlast  = (word_cnt == WCNT_W'(PKT_WORDS-1));
            pop       = outTready;
            pkt_done  = outTready && outTlast;
            if (pkt_done) state_nxt = IDLE;
         end
         DROP: begin
            pop      = 1'b1;
            pkt_done = (word_cnt == WCNT_W'(PKT_WORDS-1));
            if (pkt_done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sysClk) begin
      if (sysReset) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         outLink  <= '0;
         word_cnt <= '0;
         fwd_cnt  <= '0;
         for (int unsigned k = 0; k < NUM_LINKS; k++) begin
            rd_ptr[k]  <= '0;
            pending[k] <= '0;
         end
      end else begin
         state <= state_nxt;
         if (state == IDLE && grant_ok) begin
            outLink <= grant;
            rr_ptr  <= grant;
         end
         if (pop) begin
            rd_ptr[outLink] <= rd_ptr[outLink] + PTR_W'(1);
            word_cnt        <= pkt_done ? '0 : word_cnt + WCNT_W'(1);
         end
         if (pkt_done && state == FWD)
            fwd_cnt <= fwd_cnt + 32'd1;
         for (int unsigned k = 0; k < NUM_LINKS; k++) begin
            case ({commit[k], pkt_done && (outLink == LINK_W'(k))})
               2'b10:   pending[k] <= pending[k] + PTR_W'(1);
               2'b01:   pending[k] <= pending[k] - PTR_W'(1);
               default: pending[k] <= pending[k];
            endcase
         end
      end
   end

`ifdef CELL_COMM_MERGE_DEDUP_EN
   logic [2**FOFB_IDX_WIDTH-1:0] seen;
   logic [FOFB_IDX_WIDTH-1:0]    hdr_idx;
   logic [31:0]                  dup_cnt;

   assign dup_hit  = seen[head[FOFB_IDX_WIDTH-1:0]];
   assign dupCount = dup_cnt;

   // the set is ordered after the clear so a same-cycle forward survives the FA strobe
   always_ff @(posedge sysClk) begin
      if (sysReset) begin
         seen    <= '0;
         hdr_idx <= '0;
         dup_cnt <= '0;
      end else begin
         if (sysFaStrobe)
            seen <= '0;
         if (state == CHECK)
            hdr_idx <= head[FOFB_IDX_WIDTH-1:0];
         if (pkt_done && state == FWD)
            seen[hdr_idx] <= 1'b1;
         if (pkt_done && state == DROP)
            dup_cnt <= dup_cnt + 32'd1;
      end
   end
`else
   logic unused_fa_strobe;
   assign unused_fa_strobe = sysFaStrobe;
   assign dup_hit  = 1'b0;
   assign dupCount = '0;
`endif

   assign fwdCount = fwd_cnt;

   always_comb begin
      for (int unsigned k = 0; k < NUM_LINKS; k++) begin
         crcFaults[k*32 +: 32] = crc_cnt[k];
         dropCount[k*32 +: 32] = drop_cnt[k];
      end
   end

endmodule

// File: tb/tb_cell_comm_link_merge.sv
// Scoreboard bench for cell_comm_link_merge: directed packets per link, expected merged
// beats queued by the driver and checked by an independent output monitor.
`timescale 1ns/1ps
module tb_cell_comm_link_merge;

   localparam int NL = 2;
   localparam int DW = 32;
   localparam int PW = 4;

   logic           sysClk = 1'b0;
   logic           sysReset, sysFaStrobe;
   logic [NL-1:0]  rxChannelUp, rxTvalid, rxTlast, rxCRCvalid, rxCRCpass;
   logic [NL*DW-1:0] rxTdata;
   logic           outTvalid, outTlast, outTready;
   logic [DW-1:0]  outTdata;
   logic           outLink;
   logic [NL*32-1:0] crcFaults, dropCount;
   logic [31:0]    dupCount, fwdCount;

   always #5 sysClk = ~sysClk;

   cell_comm_link_merge #(
      .NUM_LINKS(NL), .DATA_WIDTH(DW), .FOFB_IDX_WIDTH(9), .PKT_WORDS(PW), .FIFO_AW(3)
   ) dut (
      .sysClk(sysClk), .sysReset(sysReset), .sysFaStrobe(sysFaStrobe),
      .rxChannelUp(rxChannelUp), .rxTvalid(rxTvalid), .rxTlast(rxTlast), .rxTdata(rxTdata),
      .rxCRCvalid(rxCRCvalid), .rxCRCpass(rxCRCpass),
      .outTvalid(outTvalid), .outTlast(outTlast), .outTdata(outTdata), .outTready(outTready),
      .outLink(outLink), .crcFaults(crcFaults), .dropCount(dropCount),
      .dupCount(dupCount), .fwdCount(fwdCount)
   );

   typedef struct packed {
      logic [31:0] data;
      logic        last;
      logic        link;
   } exp_t;

   exp_t        q[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          tlast_cyc = 0;
   bit          lat_arm = 1'b0;
   int          exp_fwd, exp_dup;
   int          exp_crc [NL];
   int          exp_drop[NL];
   logic        mon_pv, mon_pr;
   logic [31:0] mon_pd;

   always @(posedge sysClk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] word(input int k, input int i, input logic [8:0] idx,
                                        input logic [7:0] seq);
      if (i == 0) return {23'h0, idx};
      return {16'h0, seq + 8'(k), 8'(i)};
   endfunction

   // Output monitor: pops the scoreboard on every accepted beat, checks stall stability.
   initial begin
      exp_t e;
      mon_pv = 1'b0; mon_pr = 1'b0; mon_pd = '0;
      forever begin
         @(negedge sysClk);
         if (sysReset) begin
            mon_pv = 1'b0;
         end else begin
            if (mon_pv && !mon_pr) begin
               chk("hold_valid", {31'h0, outTvalid}, 32'h1);
               chk("hold_data", outTdata, mon_pd);
            end
            if (outTvalid && lat_arm) begin
               lat_arm = 1'b0;
               chk("latency", cyc - tlast_cyc, 32'd3);
            end
            if (outTvalid && outTready) begin
               if (q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat: got data 0x%0h link %0d, expected no beat",
                           outTdata, outLink);
               end else begin
                  e = q.pop_front();
                  chk("data", outTdata, e.data);
                  chk("last", {31'h0, outTlast}, {31'h0, e.last});
                  chk("link", {31'h0, outLink}, {31'h0, e.link});
               end
            end
            mon_pv = outTvalid;
            mon_pr = outTready;
            mon_pd = outTdata;
         end
      end
   end

   task automatic beat(input logic [1:0] v, input logic [1:0] l, input logic [1:0] pass,
                       input logic [31:0] d0, input logic [31:0] d1);
      rxTvalid = v; rxTlast = l; rxCRCvalid = l; rxCRCpass = pass & l;
      rxTdata  = {d1, d0};
      if (|l) tlast_cyc = cyc;
      @(posedge sysClk); #1;
      rxTvalid = '0; rxTlast = '0; rxCRCvalid = '0; rxCRCpass = '0;
   endtask

   task automatic send(input logic [1:0] mask, input int n, input logic [8:0] idx0,
                       input logic [8:0] idx1, input logic [7:0] seq, input bit ok);
      for (int i = 0; i < n; i++)
         beat(mask, (i == n-1) ? mask : 2'b00, ok ? mask : 2'b00,
              word(0, i, idx0, seq), word(1, i, idx1, seq));
   endtask

   task automatic expect_pkt(input int k, input logic [8:0] idx, input logic [7:0] seq);
      for (int i = 0; i < PW; i++)
         q.push_back('{data: word(k, i, idx, seq), last: (i == PW-1), link: 1'(k)});
      exp_fwd++;
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || outTvalid) && n < 300) begin
         @(posedge sysClk);
         n++;
      end
      repeat (8) @(posedge sysClk);
      #1;
      if (n >= 300) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d beats outstanding, expected 0", q.size());
         q.delete();
      end
   endtask

   task automatic chk_counters();
      chk("fwdCount", fwdCount, exp_fwd);
      chk("dupCount", dupCount, exp_dup);
      chk("crcFaults0", crcFaults[31:0], exp_crc[0]);
      chk("crcFaults1", crcFaults[63:32], exp_crc[1]);
      chk("dropCount0", dropCount[31:0], exp_drop[0]);
      chk("dropCount1", dropCount[63:32], exp_drop[1]);
   endtask

   task automatic do_reset();
      sysReset = 1'b1;
      repeat (2) @(posedge sysClk);
      #1;
      q.delete();
      exp_fwd = 0; exp_dup = 0;
      for (int k = 0; k < NL; k++) begin
         exp_crc[k] = 0;
         exp_drop[k] = 0;
      end
      chk("rst_valid", {31'h0, outTvalid}, 32'h0);
      chk("rst_last", {31'h0, outTlast}, 32'h0);
      chk("rst_data", outTdata, 32'h0);
      chk("rst_link", {31'h0, outLink}, 32'h0);
      chk_counters();
      sysReset = 1'b0;
      @(posedge sysClk); #1;
   endtask

   task automatic pulse_fa();
      sysFaStrobe = 1'b1;
      @(posedge sysClk); #1;
      sysFaStrobe = 1'b0;
   endtask

   initial begin
      sysReset = 1'b1; sysFaStrobe = 1'b0; rxChannelUp = 2'b11; outTready = 1'b1;
      rxTvalid = '0; rxTlast = '0; rxCRCvalid = '0; rxCRCpass = '0; rxTdata = '0;
      @(posedge sysClk); #1;
      do_reset();

      // 1: single clean packet on link0, latency measured from its tlast beat
      lat_arm = 1'b1;
      expect_pkt(0, 9'h005, 8'h00);
      send(2'b01, 4, 9'h005, 9'h0, 8'h00, 1'b1);
      drain();
      chk_counters();

      // 2: CRC-failed packet on link1 must vanish and not corrupt the next one
      pulse_fa();
      send(2'b10, 4, 9'h0, 9'h009, 8'h20, 1'b0);
      exp_crc[1]++;
      expect_pkt(1, 9'h010, 8'h21);
      send(2'b10, 4, 9'h0, 9'h010, 8'h21, 1'b1);
      drain();
      chk_counters();

      // 3: simultaneous commits from reset RR state alternate link1 then link0
      do_reset();
      for (int p = 0; p < 3; p++) begin
         expect_pkt(1, 9'(9'h041 + 2*p), 8'(8'h30 + 2*p));
         expect_pkt(0, 9'(9'h040 + 2*p), 8'(8'h30 + 2*p));
         send(2'b11, 4, 9'(9'h040 + 2*p), 9'(9'h041 + 2*p), 8'(8'h30 + 2*p), 1'b1);
         drain();
      end
      chk_counters();

      // 4: same BPM index twice in one FA cycle, then again after the strobe
      pulse_fa();
      expect_pkt(0, 9'h007, 8'h50);
      send(2'b01, 4, 9'h007, 9'h0, 8'h50, 1'b1);
      drain();
`ifdef CELL_COMM_MERGE_DEDUP_EN
      exp_dup++;
`else
      expect_pkt(1, 9'h007, 8'h52);
`endif
      send(2'b10, 4, 9'h0, 9'h007, 8'h52, 1'b1);
      drain();
      chk_counters();
      pulse_fa();
      expect_pkt(0, 9'h007, 8'h54);
      send(2'b01, 4, 9'h007, 9'h0, 8'h54, 1'b1);
      drain();
      chk_counters();

      // 5: short, long and channel-dropped packets on link1, then recovery
      pulse_fa();
      send(2'b10, 3, 9'h0, 9'h011, 8'h58, 1'b1);
      exp_drop[1]++;
      send(2'b10, 5, 9'h0, 9'h012, 8'h5a, 1'b1);
      exp_drop[1]++;
      beat(2'b10, 2'b00, 2'b00, 32'h0, 32'h013);
      beat(2'b10, 2'b00, 2'b00, 32'h0, 32'h5c01);
      rxChannelUp = 2'b01;
      exp_drop[1]++;
      repeat (2) @(posedge sysClk);
      #1;
      rxChannelUp = 2'b11;
      drain();
      chk_counters();
      expect_pkt(1, 9'h020, 8'h60);
      send(2'b10, 4, 9'h0, 9'h020, 8'h60, 1'b1);
      drain();
      chk_counters();

      // 6: stall mid-forward while link0 overfills its 8-word FIFO
      pulse_fa();
      expect_pkt(0, 9'h030, 8'h70);
      send(2'b01, 4, 9'h030, 9'h0, 8'h70, 1'b1);
      repeat (3) @(posedge sysClk);
      #1;
      outTready = 1'b0;
      expect_pkt(0, 9'h031, 8'h72);
      send(2'b01, 4, 9'h031, 9'h0, 8'h72, 1'b1);
      send(2'b01, 4, 9'h032, 9'h0, 8'h74, 1'b1);
      exp_drop[0]++;
      repeat (2) @(posedge sysClk);
      #1;
      outTready = 1'b1;
      drain();
      chk_counters();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no completion, expected end of test");
      $fatal(1, "timeout");
   end

endmodule
